// File: rtl/seg_pkg.sv
// Active-low gfedcba glyph constants, BCD decode and tracker state type for the 7-segment capture.
// Build with SEG_HEX_EN defined to also decode the A..F glyphs.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

`ifdef SEG_HEX_EN
  localparam bit HEX_EN = 1'b1;
`else
  localparam bit HEX_EN = 1'b0;
`endif

  typedef enum logic [1:0] {SEARCH, COUNT, HELD} trk_state_t;

  // Decode results are packed as {err, blank, bcd}.
  function automatic logic [5:0] hex_glyph(input logic [3:0] v);
    return HEX_EN ? {2'b00, v} : {2'b10, 4'hE};
  endfunction

  function automatic logic [5:0] decode(input logic [6:0] seg);
    logic [5:0] r;
    r = {2'b10, 4'hE};
    case (seg)
      SEG_0:     r = {2'b00, 4'h0};
      SEG_1:     r = {2'b00, 4'h1};
      SEG_2:     r = {2'b00, 4'h2};
      SEG_3:     r = {2'b00, 4'h3};
      SEG_4:     r = {2'b00, 4'h4};
      SEG_5:     r = {2'b00, 4'h5};
      SEG_6:     r = {2'b00, 4'h6};
      SEG_7:     r = {2'b00, 4'h7};
      SEG_8:     r = {2'b00, 4'h8};
      SEG_9:     r = {2'b00, 4'h9};
      SEG_A:     r = hex_glyph(4'hA);
      SEG_B:     r = hex_glyph(4'hB);
      SEG_C:     r = hex_glyph(4'hC);
      SEG_D:     r = hex_glyph(4'hD);
      SEG_E:     r = hex_glyph(4'hE);
      SEG_F:     r = hex_glyph(4'hF);
      SEG_BLANK: r = {2'b01, 4'hF};
      default:   r = {2'b10, 4'hE};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg_display_capture_if.sv
// Frame handshake between the 7-segment capture block (master) and its consumer (slave).
interface seg_display_capture_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] bcd_out;
  logic [DIGITS-1:0]   dp_out;
  logic [DIGITS-1:0]   blank_out;
  logic [DIGITS-1:0]   err_out;
  logic                frame_valid;
  logic                frame_ready;
  logic                overrun;

  modport master (
    output bcd_out, dp_out, blank_out, err_out, frame_valid, overrun,
    input  frame_ready
  );

  modport slave (
    input  bcd_out, dp_out, blank_out, err_out, frame_valid, overrun,
    output frame_ready
  );
endinterface

// File: rtl/seg_sync.sv
// Two-flop synchronizer; resets to all ones, the idle level of the active-low display bus.
module seg_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/seg_display_capture.sv
// Captures a multiplexed common-anode 7-segment display into BCD frames handed out over valid/ready.
// state  | meaning
// SEARCH | no single digit selected; waiting for a clean select
// COUNT  | counting consecutive identical samples of the selected digit
// HELD   | digit committed; ignoring repeats until the sample changes
module seg_display_capture
  import seg_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        Segments_in,
  input  logic              bp_in,
  input  logic [DIGITS-1:0] SEL_in,
  seg_display_capture_if.master frm
);
  localparam int         SW     = 8 + DIGITS;
  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  logic [SW-1:0]       sample, prev;
  logic [DIGITS-1:0]   sel_hot, mask;
  logic [6:0]          seg_s;
  logic                bp_s, sel_ok, same, commit, frame_done;
  logic [5:0]          dec;
  trk_state_t          state, state_n;
  logic [7:0]          cnt, cnt_n;
  logic [4*DIGITS-1:0] work_bcd;
  logic [DIGITS-1:0]   work_dp, work_blank, work_err;

  seg_sync #(.WIDTH(SW)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({bp_in, Segments_in, SEL_in}),
    .q   (sample)
  );

  assign sel_hot    = ~sample[DIGITS-1:0];
  assign seg_s      = sample[DIGITS+6:DIGITS];
  assign bp_s       = sample[SW-1];
  assign sel_ok     = $onehot(sel_hot);
  assign same       = (sample == prev);
  assign dec        = decode(seg_s);
  assign frame_done = &mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEARCH;
      cnt   <= '0;
      prev  <= '1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      prev  <= sample;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    commit  = 1'b0;
    case (state)
      SEARCH: begin
        if (sel_ok) begin
          state_n = COUNT;
          cnt_n   = 8'd1;
        end
      end
      COUNT, HELD: begin
        if (!sel_ok) begin
          state_n = SEARCH;
          cnt_n   = '0;
        end else if (!same) begin
          state_n = COUNT;
          cnt_n   = 8'd1;
        end else if (state == COUNT) begin
          cnt_n = cnt + 8'd1;
          if (cnt_n == STABLE) begin
            commit  = 1'b1;
            state_n = HELD;
          end
        end
      end
      default: begin
        state_n = SEARCH;
        cnt_n   = '0;
      end
    endcase
  end

  // A commit landing on the same edge as frame completion belongs to the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask       <= '0;
      work_bcd   <= '1;
      work_dp    <= '0;
      work_blank <= '1;
      work_err   <= '0;
    end else begin
      mask <= (frame_done ? '0 : mask) | (commit ? sel_hot : '0);
      if (commit) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (sel_hot[i]) begin
            work_bcd[4*i +: 4] <= dec[3:0];
            work_blank[i]      <= dec[4];
            work_err[i]        <= dec[5];
            work_dp[i]         <= ~bp_s;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frm.bcd_out     <= '1;
      frm.dp_out      <= '0;
      frm.blank_out   <= '1;
      frm.err_out     <= '0;
      frm.frame_valid <= 1'b0;
      frm.overrun     <= 1'b0;
    end else begin
      if (frame_done && (!frm.frame_valid || frm.frame_ready)) begin
        frm.bcd_out     <= work_bcd;
        frm.dp_out      <= work_dp;
        frm.blank_out   <= work_blank;
        frm.err_out     <= work_err;
        frm.frame_valid <= 1'b1;
      end else if (frm.frame_valid && frm.frame_ready) begin
        frm.frame_valid <= 1'b0;
      end
      if (frame_done && frm.frame_valid && !frm.frame_ready) begin
        frm.overrun <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seg_display_capture.sv
// Scoreboard bench for seg_display_capture: stimulus pushes expected frames, a monitor pops on handshake.
`timescale 1ns/1ps
module tb_seg_display_capture;
  localparam int DIGITS = 4;
  localparam int STABLE = 8;

`ifdef SEG_HEX_EN
  localparam bit HEX = 1'b1;
`else
  localparam bit HEX = 1'b0;
`endif

  // glyphs 0..9 then A..F, active-low gfedcba
  localparam logic [6:0] PAT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
    7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  err;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg;
  logic       bp;
  logic [3:0] sel;

  seg_display_capture_if #(.DIGITS(DIGITS)) frm ();

  seg_display_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .Segments_in (seg),
    .bp_in       (bp),
    .SEL_in      (sel),
    .frm         (frm)
  );

  always #5 clk = ~clk;

  int     n_vec = 0;
  int     n_bad = 0;
  frame_t exp_q[$];
  frame_t m_work, m_last, a_frame, mon_e;
  logic [3:0] m_mask;
  bit     m_drop;
  int     rd, rh, rv;
  logic [6:0] rp;

  function automatic logic [5:0] ref_decode(input logic [6:0] p);
    if (p == 7'h7F) return {2'b01, 4'hF};
    for (int v = 0; v < 16; v++) begin
      if (PAT[v] == p && (v < 10 || HEX)) return {2'b00, 4'(v)};
    end
    return {2'b10, 4'hE};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic check_reset(input string name);
    check(name, 64'({frm.bcd_out, frm.dp_out, frm.blank_out, frm.err_out, frm.frame_valid, frm.overrun}),
          64'({16'hFFFF, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0}));
  endtask

  function automatic logic [63:0] outs();
    return 64'({frm.bcd_out, frm.dp_out, frm.blank_out, frm.err_out});
  endfunction

  task automatic model_commit(input int d, input logic [6:0] p, input logic b);
    logic [5:0] r;
    r = ref_decode(p);
    m_work.bcd[4*d +: 4] = r[3:0];
    m_work.blank[d]      = r[4];
    m_work.err[d]        = r[5];
    m_work.dp[d]         = ~b;
    m_mask[d]            = 1'b1;
    if (&m_mask) begin
      m_mask = '0;
      m_last = m_work;
      if (!m_drop) exp_q.push_back(m_work);
    end
  endtask

  // Hold one digit for h clocks, then a 1..3 clock idle gap so the next digit starts fresh.
  task automatic drive(input int d, input logic [6:0] p, input logic b, input int h, input bit pulse);
    int g;
    seg = p; bp = b; sel = ~(4'b0001 << d);
    for (int c = 1; c <= h; c++) begin
      @(posedge clk); #1;
      if (c == STABLE) model_commit(d, p, b);
      if (pulse && c == STABLE + 2) frm.frame_ready = 1'b1;
      if (pulse && c == STABLE + 3) frm.frame_ready = 1'b0;
    end
    g = $urandom_range(1, 3);
    sel = '1; seg = 7'($urandom); bp = 1'($urandom);
    repeat (g) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && frm.frame_valid && frm.frame_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_frame: got %h, required no frame", outs());
      end else begin
        mon_e = exp_q.pop_front();
        check("frame", outs(), 64'(mon_e));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    seg = 7'h7F; bp = 1'b1; sel = '1; frm.frame_ready = 1'b0;
    m_mask = '0; m_drop = 1'b0; m_work = '0; m_last = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2 check_reset("reset_values");
    #19 rst = 1'b0;
    @(posedge clk); #1;

    // basic frame 3,7,0,9
    frm.frame_ready = 1'b1;
    drive(0, PAT[3], 1'b1, 20, 1'b0);
    drive(1, PAT[7], 1'b1, 20, 1'b0);
    drive(2, PAT[0], 1'b1, 20, 1'b0);
    drive(3, PAT[9], 1'b1, 20, 1'b0);
    repeat (4) @(posedge clk); #1;

    // digit 1 held too briefly
    frm.frame_ready = 1'b0;
    drive(0, PAT[5], 1'b1, 10, 1'b0);
    drive(2, PAT[6], 1'b1, 10, 1'b0);
    drive(3, PAT[1], 1'b1, 10, 1'b0);
    drive(1, PAT[4], 1'b1, 5, 1'b0);
    drive(1, PAT[4], 1'b1, STABLE - 1, 1'b0);
    repeat (5) @(posedge clk); #1;
    check("short_hold_no_frame", 64'(frm.frame_valid), 64'(0));
    drive(1, PAT[4], 1'b1, STABLE, 1'b0);
    repeat (3) @(posedge clk); #1;
    check("exact_hold_frame", 64'(frm.frame_valid), 64'(1));
    frm.frame_ready = 1'b1;
    repeat (3) @(posedge clk); #1;

    // blank digit, hex glyph with decimal point
    drive(2, 7'h7F, 1'b1, 10, 1'b0);
    drive(0, PAT[10], 1'b0, 10, 1'b0);
    drive(1, PAT[4], 1'b1, 10, 1'b0);
    drive(3, PAT[8], 1'b0, 10, 1'b0);
    repeat (4) @(posedge clk); #1;

    // two selects active must never commit
    frm.frame_ready = 1'b0;
    drive(1, PAT[2], 1'b1, 10, 1'b0);
    drive(2, PAT[3], 1'b1, 10, 1'b0);
    drive(3, PAT[4], 1'b1, 10, 1'b0);
    sel = 4'b1100; seg = PAT[5]; bp = 1'b1;
    repeat (50) @(posedge clk); #1;
    sel = '1;
    repeat (3) @(posedge clk); #1;
    check("ghost_select_no_frame", 64'(frm.frame_valid), 64'(0));
    drive(0, PAT[2], 1'b1, 10, 1'b0);
    repeat (4) @(posedge clk); #1;
    check("after_ghost_frame", 64'(frm.frame_valid), 64'(1));
    frm.frame_ready = 1'b1;
    repeat (3) @(posedge clk); #1;

    // randomized digits, patterns and hold lengths
    for (int k = 0; k < 48; k++) begin
      rd = $urandom_range(0, 3);
      rh = $urandom_range(STABLE - 2, STABLE + 4);
      rv = $urandom_range(0, 19);
      if (rv < 16) rp = PAT[rv];
      else if (rv == 16) rp = 7'h7F;
      else rp = 7'($urandom);
      drive(rd, rp, 1'($urandom), rh, 1'b0);
    end
    repeat (10) @(posedge clk); #1;
    check("no_overrun_when_ready", 64'(frm.overrun), 64'(0));

    // reset in the middle of a partial frame
    rst = 1'b1; #2 rst = 1'b0;
    m_mask = '0; exp_q.delete();
    @(posedge clk); #1;
    drive(0, PAT[1], 1'b1, 10, 1'b0);
    drive(1, PAT[2], 1'b1, 10, 1'b0);
    drive(2, PAT[3], 1'b1, 10, 1'b0);
    drive(3, PAT[4], 1'b1, 10, 1'b0);
    repeat (4) @(posedge clk); #1;
    drive(0, PAT[5], 1'b1, 10, 1'b0);
    drive(1, PAT[6], 1'b1, 10, 1'b0);
    seg = PAT[7]; bp = 1'b1; sel = 4'b1011;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset("async_reset_mid_count");
    seg = 7'h7F; sel = '1;
    m_mask = '0; exp_q.delete();
    #2 rst = 1'b0;
    @(posedge clk); #1;
    frm.frame_ready = 1'b0;
    drive(2, PAT[7], 1'b1, 10, 1'b0);
    drive(3, PAT[8], 1'b1, 10, 1'b0);
    repeat (5) @(posedge clk); #1;
    check("reset_discards_partial", 64'(frm.frame_valid), 64'(0));
    drive(0, PAT[9], 1'b1, 10, 1'b0);
    drive(1, PAT[0], 1'b1, 10, 1'b0);
    repeat (4) @(posedge clk); #1;
    check("full_frame_after_reset", 64'(frm.frame_valid), 64'(1));
    frm.frame_ready = 1'b1;
    repeat (3) @(posedge clk); #1;

    // overrun: consumer stalls across two frames
    frm.frame_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive(i, PAT[i + 1], 1'b1, 10, 1'b0);
    a_frame = m_last;
    repeat (3) @(posedge clk); #1;
    check("first_frame_valid", 64'(frm.frame_valid), 64'(1));
    check("no_overrun_yet", 64'(frm.overrun), 64'(0));
    m_drop = 1'b1;
    for (int i = 0; i < 4; i++) drive(i, PAT[i + 5], 1'b0, 10, 1'b0);
    m_drop = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("overrun_set", 64'(frm.overrun), 64'(1));
    check("first_frame_retained", outs(), 64'(a_frame));
    drive(0, PAT[9], 1'b1, 10, 1'b0);
    drive(1, PAT[0], 1'b1, 10, 1'b0);
    drive(2, PAT[1], 1'b0, 10, 1'b0);
    drive(3, PAT[2], 1'b1, STABLE + 6, 1'b1);
    check("valid_kept_on_accept_and_complete", 64'(frm.frame_valid), 64'(1));
    check("reloaded_frame", outs(), 64'(m_last));
    frm.frame_ready = 1'b1;
    repeat (4) @(posedge clk); #1;
    check("overrun_sticky", 64'(frm.overrun), 64'(1));

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d frames never presented, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/seg_display_capture.md
# seg_display_capture

Receive side of the multiplexed common-anode 7-segment display bus. Samples the active-low segment, decimal-point and digit-select lines produced by the display drivers. Requires each digit's pattern to be stable before decoding it back to BCD, then presents a complete multi-digit frame to a consumer over a valid/ready handshake. Used for display loop-back checking and for reading external instruments that drive 7-segment panels.

## Interface
- DIGITS, 4, number of multiplexed digits (1..8)
- STABLE_CYCLES, 8, consecutive identical synchronized samples required before a digit is committed (2..255)
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- Segments_in  input  7  gfedcba, active low, asynchronous to clk
- bp_in  input  1  decimal point, active low, asynchronous
- SEL_in  input  DIGITS  digit selects, active low; bit i selects digit i
- bcd_out  output  4*DIGITS  digit i at [4i+3:4i]
- dp_out  output  DIGITS  decimal point per digit, active high
- blank_out  output  DIGITS  digit was all segments off
- err_out  output  DIGITS  digit held an undecodable pattern
- frame_valid  output  1  frame available
- frame_ready  input  1  consumer accepts frame
- overrun  output  1  sticky: a frame completed while the previous one was unaccepted

## Operation
- Segments_in, bp_in and SEL_in pass through a two-flop synchronizer. The synchronized 8+DIGITS-bit vector is the sample.
- A select is valid only when exactly one SEL bit is low. Zero or multiple low bits mean ghosting or blanking, and the sample is ignored.
- Tracker FSM:
  - SEARCH: select invalid, stay. Select valid, go to COUNT with cnt=1.
  - COUNT: sample equals previous, cnt++. Sample changed with valid select, cnt=1. Select invalid, go to SEARCH. When cnt reaches STABLE_CYCLES, commit the digit and go to HELD.
  - HELD: unchanged sample, stay; no re-commit. Changed sample, go to COUNT with cnt=1 or to SEARCH, by the same rules as COUNT.
- Commit decodes the segment pattern into working register i and sets bit i of mask.
- Decode, using active-low gfedcba patterns:
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9.
  - 1111111 gives bcd=F and blank=1.
  - Any other pattern gives bcd=E and err=1.
  - dp = ~bp.
- Frame completion: when mask is all ones, the working registers are copied to the outputs, frame_valid is set and mask is cleared.
- Completion while frame_valid=1 and frame_ready=0: outputs are not overwritten and overrun is set. Mask is still cleared and capture continues.
- frame_ready=1 while frame_valid=1 accepts the frame.
  - Accept and completion in the same cycle: outputs reload, frame_valid stays 1, no overrun.
  - Otherwise frame_valid clears.
- overrun is cleared only by rst.

## Timing
- Reset values:
  - Outputs: bcd_out=all F, blank_out=all 1, dp_out=0, err_out=0, frame_valid=0, overrun=0.
  - Internal: mask=0, FSM=SEARCH, cnt=0, synchronizers all 1, which is the idle level.
- Latency: an input change is visible in the sample after 2 clk. The commit occurs on the edge where the STABLE_CYCLES-th identical sample is seen.
- frame_valid rises on the edge after the final commit. Outputs change only on that same edge.
- Outputs stay constant while frame_valid=1 and frame_ready=0.
- rst mid-operation discards any partial frame and any pending frame immediately, without waiting for a clock edge.

## Configuration
- SEG_HEX_EN
  - Defined: additionally decode 0001000=A, 0000011=b, 1000110=C, 0100001=d, 0000110=E, 0001110=F as values A..F. These results have err=0 and blank=0.
  - Not defined: these patterns are errors (bcd=E, err=1).
  - In both builds, blank is distinguished from hex F by blank_out.

## Structure
- Package seg_pkg:
  - Active-low pattern constants for 0..9 and A..F, plus SEG_BLANK.
  - decode function returning {err, blank, bcd}.
  - Tracker state enum (SEARCH, COUNT, HELD).
- Sub-module seg_sync: parameterized-width two-flop synchronizer with async active-high reset to 1.

## Test plan
- DIGITS=4, STABLE_CYCLES=8; drive digits 0..3 with patterns 3, 7, 0, 9 for 20 clk each -> frame_valid rises; bcd_out=16'h9073, err_out=0, blank_out=0.
- Hold digit 1 pattern for only 5 clk, then switch digit -> digit 1 not committed; no frame_valid until digit 1 is held for 8 samples.
- Drive digit 2 with 1111111, and digit 0 with 0001000 and bp_in=0 -> blank_out[2]=1 with bcd F; digit 0 gives dp_out[0]=1 plus bcd=E, err=1 without SEG_HEX_EN, or bcd=A, err=0 with it.
- Drive SEL_in=4'b1100 (two selects active) for 50 clk -> no commit, FSM stays in SEARCH.
- Hold frame_ready=0 across two complete frames -> first frame retained on outputs, overrun=1. Then frame_ready=1 in the cycle of the next completion -> outputs reload, frame_valid stays 1.
- Assert rst mid-count after 2 committed digits -> outputs return to reset values; the next frame needs all 4 digits again.
